// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence memory game: state codes and the
// default 16x4 sequence table used when no ROM file is supplied.
package jogo_pkg;

  // State codes are visible on db_estado, so their values are fixed.
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    ESPERA         = 4'h2,
    REGISTRA       = 4'h3,
    COMPARA        = 4'h4,
    PROXIMO        = 4'h5,
    PROXIMA_RODADA = 4'h6,
    FIM_ACERTO     = 4'hA,
    FIM_ERRO       = 4'hE
  } estado_t;

  // Entry 0 sits in the least significant nibble:
  // 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4
  localparam logic [63:0] ROM_PADRAO = 64'h4188_4422_1124_8421;

  function automatic logic [3:0] rom_padrao(input logic [3:0] a);
    return ROM_PADRAO[{a, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sync_rom_param.sv
// Synchronous-read ROM with a 1-cycle latency, backed by the package table.
module sync_rom_param
  import jogo_pkg::*;
#(
  parameter int    WIDTH    = 4,
  parameter int    ADDR_W   = 4,
  parameter string ROM_FILE = ""
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [WIDTH-1:0]  o_dado
);

  logic [WIDTH-1:0] r_dado;

  always_ff @(posedge clock) r_dado <= WIDTH'(rom_padrao(4'(i_addr)));

  assign o_dado = r_dado;

endmodule

// File: rtl/jogo_sequencia_rodadas.sv
// Memory game with growing rounds. Round k asks the player to repeat ROM
// entries 0..k. The game is won once the whole ROM is reproduced, and lost on
// the first mismatch. The optional ESPERA timeout is enabled by defining the
// macro JOGO_TIMEOUT_EN.
module jogo_sequencia_rodadas
  import jogo_pkg::*;
#(
  parameter int    WIDTH          = 4,
  parameter int    ADDR_W         = 4,
  parameter string ROM_FILE       = "",
  parameter int    TIMEOUT_CYCLES = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [WIDTH-1:0]  chaves,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic [3:0]        db_estado,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [ADDR_W-1:0] db_limite,
  output logic [WIDTH-1:0]  db_memoria,
  output logic [WIDTH-1:0]  db_chaves,
  output logic              db_igual,
  output logic              db_timeout
);

  localparam int                DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(DEPTH-1);

  estado_t           r_estado;
  logic [ADDR_W-1:0] r_contagem;
  logic [ADDR_W-1:0] r_limite;
  logic [WIDTH-1:0]  r_chaves;
  logic [WIDTH-1:0]  r_chaves_ant;
  logic [WIDTH-1:0]  w_memoria;
  logic              w_igual;
  logic              w_jogada;
  logic              w_estouro;

  // The ROM is read every cycle from the current address.
  sync_rom_param #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .ROM_FILE(ROM_FILE)
  ) u_rom (
    .clock (clock),
    .i_addr(r_contagem),
    .o_dado(w_memoria)
  );

  assign w_igual  = (w_memoria == r_chaves);
  // A press is a rising edge from "no key" to "some key". Holding a key down
  // therefore never counts as a second press.
  assign w_jogada = (chaves != '0) && (r_chaves_ant == '0);

  // previous-keys register for press edge detection, updated every cycle
  always_ff @(posedge clock) begin
    if (reset) r_chaves_ant <= '0;
    else       r_chaves_ant <= chaves;
  end

`ifdef JOGO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_cont_to;
  logic            r_timeout;

  assign w_estouro = (r_estado == ESPERA) && !w_jogada &&
                     (r_cont_to == TO_W'(TIMEOUT_CYCLES - 1));

  // idle counter: restarts for every expected press, counts idle ESPERA cycles
  always_ff @(posedge clock) begin
    if (reset || r_estado == PREPARA || r_estado == PROXIMO ||
        r_estado == PROXIMA_RODADA)
      r_cont_to <= '0;
    else if (r_estado == ESPERA && !w_jogada)
      r_cont_to <= r_cont_to + TO_W'(1);
  end

  // sticky timeout flag, cleared only by reset or a new game
  always_ff @(posedge clock) begin
    if (reset || r_estado == PREPARA) r_timeout <= 1'b0;
    else if (w_estouro)               r_timeout <= 1'b1;
  end

  assign db_timeout = r_timeout;
`else
  assign w_estouro  = 1'b0;
  assign db_timeout = 1'b0;
`endif

  // round controller
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      case (r_estado)
        INICIAL:        if (iniciar) r_estado <= PREPARA;
        PREPARA:        r_estado <= ESPERA;
        ESPERA: begin
          if (w_jogada)       r_estado <= REGISTRA;
          else if (w_estouro) r_estado <= FIM_ERRO;
        end
        REGISTRA:       r_estado <= COMPARA;
        COMPARA: begin
          if (!w_igual)                  r_estado <= FIM_ERRO;
          else if (r_contagem != r_limite) r_estado <= PROXIMO;
          else if (r_limite != ULTIMO)   r_estado <= PROXIMA_RODADA;
          else                           r_estado <= FIM_ACERTO;
        end
        PROXIMO:        r_estado <= ESPERA;
        PROXIMA_RODADA: r_estado <= ESPERA;
        FIM_ACERTO,
        FIM_ERRO:       if (iniciar) r_estado <= PREPARA;
        default:        r_estado <= INICIAL;
      endcase
    end
  end

  // Address, round limit and key register. They never wrap: COMPARA stops the
  // game before either counter could pass the last entry.
  always_ff @(posedge clock) begin
    if (reset || r_estado == PREPARA) begin
      r_contagem <= '0;
      r_limite   <= '0;
      r_chaves   <= '0;
    end else begin
      case (r_estado)
        REGISTRA:       r_chaves   <= chaves;
        PROXIMO:        r_contagem <= r_contagem + ADDR_W'(1);
        PROXIMA_RODADA: begin
          r_limite   <= r_limite + ADDR_W'(1);
          r_contagem <= '0;
        end
        default: ;
      endcase
    end
  end

  assign pronto      = (r_estado == FIM_ACERTO) || (r_estado == FIM_ERRO);
  assign acertou     = (r_estado == FIM_ACERTO);
  assign errou       = (r_estado == FIM_ERRO);
  assign db_estado   = r_estado;
  assign db_contagem = r_contagem;
  assign db_limite   = r_limite;
  assign db_memoria  = w_memoria;
  assign db_chaves   = r_chaves;
  assign db_igual    = w_igual;

endmodule

// File: tb/tb_jogo_sequencia_rodadas.sv
// Bench for jogo_sequencia_rodadas: a table of scripted presses, hand-written
// corner sequences, and random games checked against a round/index model.
module tb_jogo_sequencia_rodadas;

  logic       clock = 1'b0;
  logic       reset, iniciar;
  logic [3:0] chaves;
  logic       pronto, acertou, errou, db_igual, db_timeout;
  logic [3:0] db_estado, db_contagem, db_limite, db_memoria, db_chaves;

  jogo_sequencia_rodadas #(
    .WIDTH(4), .ADDR_W(4), .ROM_FILE(""), .TIMEOUT_CYCLES(20)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .pronto(pronto), .acertou(acertou), .errou(errou),
    .db_estado(db_estado), .db_contagem(db_contagem), .db_limite(db_limite),
    .db_memoria(db_memoria), .db_chaves(db_chaves), .db_igual(db_igual),
    .db_timeout(db_timeout)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // expected sequence, written out independently of the package
  int rom_ref [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};

  // game model: current round, index inside round, outcome, last key
  int m_rod, m_idx, m_fim, m_ult;   // m_fim: 0 playing, 1 won, 2 lost

  typedef struct {
    logic [3:0] k;
    int est, cont, lim, pr, ac, er, chv;
  } vet_t;
  vet_t tab [5];

  task automatic chk(input string nome, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // one press: hold through ESPERA and REGISTRA, release, settle back
  task automatic aperta(input logic [3:0] v);
    chaves = v;
    step(2);
    chaves = 4'd0;
    step(2);
  endtask

  task automatic reseta;
    reset = 1'b1; chaves = 4'd0; iniciar = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic inicia;
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    step(1);
    m_rod = 0; m_idx = 0; m_fim = 0; m_ult = 0;
  endtask

  task automatic modelo(input int v);
    m_ult = v;
    if (v != rom_ref[m_idx]) m_fim = 2;
    else if (m_idx < m_rod)  m_idx++;
    else if (m_rod < 15)     begin m_rod++; m_idx = 0; end
    else                     m_fim = 1;
  endtask

  task automatic confere(input string tag);
    chk({tag, " estado"},  int'(db_estado), (m_fim == 0) ? 2 : ((m_fim == 1) ? 10 : 14));
    chk({tag, " contagem"}, int'(db_contagem), m_idx);
    chk({tag, " limite"},  int'(db_limite), m_rod);
    chk({tag, " chaves"},  int'(db_chaves), m_ult);
    chk({tag, " pronto"},  int'(pronto), int'(m_fim != 0));
    chk({tag, " acertou"}, int'(acertou), int'(m_fim == 1));
    chk({tag, " errou"},   int'(errou), int'(m_fim == 2));
    if (m_fim != 0) begin
      chk({tag, " memoria"}, int'(db_memoria), rom_ref[m_idx]);
      chk({tag, " igual"},   int'(db_igual), int'(m_fim == 1));
    end
  endtask

  task automatic zeros(input string tag);
    chk({tag, " estado"},   int'(db_estado), 0);
    chk({tag, " contagem"}, int'(db_contagem), 0);
    chk({tag, " limite"},   int'(db_limite), 0);
    chk({tag, " chaves"},   int'(db_chaves), 0);
    chk({tag, " pronto"},   int'(pronto), 0);
    chk({tag, " acertou"},  int'(acertou), 0);
    chk({tag, " errou"},    int'(errou), 0);
    chk({tag, " timeout"},  int'(db_timeout), 0);
  endtask

  initial begin
    // press, estado, contagem, limite, pronto, acertou, errou, chaves
    tab[0] = '{k: 4'd1, est: 2,  cont: 0, lim: 1, pr: 0, ac: 0, er: 0, chv: 1};
    tab[1] = '{k: 4'd1, est: 2,  cont: 1, lim: 1, pr: 0, ac: 0, er: 0, chv: 1};
    tab[2] = '{k: 4'd2, est: 2,  cont: 0, lim: 2, pr: 0, ac: 0, er: 0, chv: 2};
    tab[3] = '{k: 4'd1, est: 2,  cont: 1, lim: 2, pr: 0, ac: 0, er: 0, chv: 1};
    tab[4] = '{k: 4'd4, est: 14, cont: 1, lim: 2, pr: 1, ac: 0, er: 1, chv: 4};

    chaves = 4'd0; iniciar = 1'b0; reset = 1'b1;
    step(2);
    zeros("reset");
    reset = 1'b0;
    step(1);
    chk("reset memoria", int'(db_memoria), 1);
    chk("reset igual", int'(db_igual), 0);

    // presses before iniciar are ignored
    aperta(4'd1);
    chk("idle press estado", int'(db_estado), 0);

    inicia;
    chk("start estado", int'(db_estado), 2);
    chk("start limite", int'(db_limite), 0);

    for (int i = 0; i < 5; i++) begin
      aperta(tab[i].k);
      chk($sformatf("tab%0d estado", i),   int'(db_estado), tab[i].est);
      chk($sformatf("tab%0d contagem", i), int'(db_contagem), tab[i].cont);
      chk($sformatf("tab%0d limite", i),   int'(db_limite), tab[i].lim);
      chk($sformatf("tab%0d pronto", i),   int'(pronto), tab[i].pr);
      chk($sformatf("tab%0d acertou", i),  int'(acertou), tab[i].ac);
      chk($sformatf("tab%0d errou", i),    int'(errou), tab[i].er);
      chk($sformatf("tab%0d chaves", i),   int'(db_chaves), tab[i].chv);
    end

    // FIM_ERRO holds while iniciar stays low, even with key presses
    aperta(4'd2);
    step(5);
    chk("hold estado", int'(db_estado), 14);
    chk("hold contagem", int'(db_contagem), 1);
    chk("hold errou", int'(errou), 1);

    // mismatch in round 1, restarted straight from FIM_ERRO
    inicia;
    chk("restart limite", int'(db_limite), 0);
    aperta(4'd1);
    aperta(4'd1);
    aperta(4'd4);
    chk("r1 miss estado", int'(db_estado), 14);
    chk("r1 miss contagem", int'(db_contagem), 1);
    chk("r1 miss pronto", int'(pronto), 1);

    // a held key counts once
    inicia;
    aperta(4'd1);
    aperta(4'd1);
    chaves = 4'd2;
    step(8);
    chk("held estado", int'(db_estado), 2);
    chk("held limite", int'(db_limite), 2);
    chk("held contagem", int'(db_contagem), 0);
    chaves = 4'd0;
    step(1);

    // full winning game
    reseta;
    inicia;
    for (int r = 0; r < 16; r++)
      for (int i = 0; i <= r; i++) begin
        aperta(4'(rom_ref[i]));
        modelo(rom_ref[i]);
      end
    confere("win");
    iniciar = 1'b1;
    step(1);
    chk("win restart estado", int'(db_estado), 1);
    iniciar = 1'b0;
    step(1);
    chk("win restart estado2", int'(db_estado), 2);
    chk("win restart contagem", int'(db_contagem), 0);
    chk("win restart limite", int'(db_limite), 0);
    chk("win restart chaves", int'(db_chaves), 0);
    chk("win restart pronto", int'(pronto), 0);

    // reset while waiting in round 3
    m_rod = 0; m_idx = 0; m_fim = 0; m_ult = 0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i <= r; i++) aperta(4'(rom_ref[i]));
    aperta(4'(rom_ref[0]));
    chk("pre-reset limite", int'(db_limite), 3);
    chk("pre-reset contagem", int'(db_contagem), 1);
    reseta;
    zeros("midreset");
    aperta(4'd1);
    aperta(4'd2);
    chk("midreset ignore estado", int'(db_estado), 0);

    // random games against the model
    for (int g = 0; g < 6; g++) begin
      reseta;
      inicia;
      for (int p = 0; p < 200 && m_fim == 0; p++) begin
        logic [3:0] v;
        step($urandom_range(0, 3));
        if ($urandom_range(0, 19) != 0) v = 4'(rom_ref[m_idx]);
        else                            v = 4'($urandom_range(1, 15));
        aperta(v);
        modelo(int'(v));
        confere($sformatf("g%0d p%0d", g, p));
      end
    end

`ifdef JOGO_TIMEOUT_EN
    reseta;
    inicia;
    step(19);
    chk("to before estado", int'(db_estado), 2);
    step(1);
    chk("to estado", int'(db_estado), 14);
    chk("to flag", int'(db_timeout), 1);
    chk("to errou", int'(errou), 1);
    inicia;
    chk("to cleared", int'(db_timeout), 0);
    step(19);
    chaves = 4'd1;
    step(1);
    chk("to press wins", int'(db_estado), 3);
    chaves = 4'd0;
    reseta;
`else
    reseta;
    inicia;
    step(100);
    chk("no-to estado", int'(db_estado), 2);
    chk("no-to flag", int'(db_timeout), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
